// File: rtl/iob_aclint_pkg.sv
// iob_aclint_pkg: shared constants and helpers for the iob_aclint core-local
// interruptor. Holds the byte-offset memory map, the CTRL bit layout, the
// hart-select width helper and the byte-lane write merge.
package iob_aclint_pkg;

    // Region bases / fixed register offsets (byte addresses)
    localparam logic [31:0] MSIP_BASE     = 32'h0000_0000;
    localparam logic [31:0] MTIMECMP_BASE = 32'h0000_4000;
    localparam logic [31:0] CTRL_ADDR     = 32'h0000_BFF0;
    localparam logic [31:0] PRESC_ADDR    = 32'h0000_BFF4;
    localparam logic [31:0] MTIME_ADDR    = 32'h0000_BFF8;
    localparam logic [31:0] SSIP_BASE     = 32'h0000_C000;
    localparam logic [31:0] SSIP_END      = 32'h0001_0000;

    // CTRL register: bit 0 enables the timebase
    localparam int CTRL_TEN_BIT = 0;

    // Width of a hart index; never zero so a single-hart build still has a select
    function automatic int hart_sel_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Merge a 32-bit bus write into an existing word, one byte lane per strobe bit
    function automatic logic [31:0] wmerge(input logic [31:0] old,
                                           input logic [31:0] d,
                                           input logic [3:0]  s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/iob_aclint_tick.sv
// iob_aclint_tick: timebase prescaler. Counts clk cycles while enabled and
// emits a registered one-cycle tick every PRESCALE+1 enabled cycles.
// Ports:
//   clk_i, arst_n_i, cke_i : clock, async active-low reset, clock enable
//   en    : count enable (CTRL.TEN)
//   presc : terminal count (PRESCALE)
//   clr   : synchronous clear of the count (PRESCALE written)
//   tick  : registered tick, high for one cycle
module iob_aclint_tick #(
    parameter int PRESC_W = 16
) (
    input  logic               clk_i,
    input  logic               arst_n_i,
    input  logic               cke_i,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    input  logic               clr,
    output logic               tick
);

    logic [PRESC_W-1:0] r_count;
    logic               r_tick;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else if (cke_i) begin
            r_tick <= 1'b0;
            if (clr) begin
                r_count <= '0;
            end else if (en) begin
                if (r_count == presc) begin
                    r_count <= '0;
                    r_tick  <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/iob_aclint.sv
// iob_aclint: ACLINT-style core-local interruptor on the IOb native bus.
// Provides per-hart MSIP/SSIP bits, per-hart 64-bit MTIMECMP, a shared 64-bit
// MTIME driven by a programmable prescaler, and registered MTIP outputs.
// Ports:
//   clk_i, arst_n_i, cke_i        : clock, async active-low reset, clock enable
//   iob_avalid_i/addr/wdata/wstrb : request (wstrb==0 is a read)
//   iob_ready_o                   : request accept (1 from first cycle after reset)
//   iob_rvalid_o/iob_rdata_o      : read response, one cycle after acceptance
//   mtip_o/msip_o/ssip_o          : per-hart interrupt lines
module iob_aclint
    import iob_aclint_pkg::*;
#(
    parameter int N_HARTS   = 1,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int PRESC_W   = 16,
    parameter int PRESC_RST = 99
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                cke_i,
    input  logic                iob_avalid_i,
    input  logic [ADDR_W-1:0]   iob_addr_i,
    input  logic [DATA_W-1:0]   iob_wdata_i,
    input  logic [DATA_W/8-1:0] iob_wstrb_i,
    output logic                iob_rvalid_o,
    output logic [DATA_W-1:0]   iob_rdata_o,
    output logic                iob_ready_o,
    output logic [N_HARTS-1:0]  mtip_o,
    output logic [N_HARTS-1:0]  msip_o,
    output logic [N_HARTS-1:0]  ssip_o
);

    localparam int HART_SEL_W = hart_sel_w(N_HARTS);

    logic                     r_ready;
    logic                     r_rvalid;
    logic [31:0]              r_rdata;
    logic [63:0]              r_mtime;
    logic [N_HARTS-1:0][63:0] r_mtimecmp;
    logic [N_HARTS-1:0]       r_msip;
    logic [N_HARTS-1:0]       r_ssip;
    logic [N_HARTS-1:0]       r_mtip;
    logic                     r_ten;
    logic [PRESC_W-1:0]       r_presc;
    logic [31:0]              r_hi_shadow;

    logic                  w_acc, w_wr, w_rd, w_tick;
    logic [31:0]           w_a, w_rdata;
    logic [31:0]           w_msip_idx, w_cmp_idx, w_ssip_idx;
    logic                  w_msip_hit, w_cmp_hit, w_ssip_hit;
    logic                  w_ctrl_sel, w_presc_sel, w_mtlo_sel, w_mthi_sel;
    logic [HART_SEL_W-1:0] w_msip_h, w_cmp_h, w_ssip_h;

    // Requests are only taken on enabled cycles so a stalled clock never
    // half-completes a transaction.
    assign w_acc = iob_avalid_i & r_ready & cke_i;
    assign w_wr  = w_acc & (|iob_wstrb_i);
    assign w_rd  = w_acc & ~(|iob_wstrb_i);

    // ---------------- address decode ----------------
    assign w_a = 32'(iob_addr_i);

    assign w_msip_idx = (w_a - MSIP_BASE) >> 2;
    assign w_cmp_idx  = (w_a - MTIMECMP_BASE) >> 3;
    assign w_ssip_idx = (w_a - SSIP_BASE) >> 2;

    // Region match plus hart-range check; out-of-range harts fall through to 0
    assign w_msip_hit = (w_a < MTIMECMP_BASE) && (w_msip_idx < 32'(N_HARTS));
    assign w_cmp_hit  = (w_a >= MTIMECMP_BASE) && (w_a < CTRL_ADDR)
                        && (w_cmp_idx < 32'(N_HARTS));
    assign w_ssip_hit = (w_a >= SSIP_BASE) && (w_a < SSIP_END)
                        && (w_ssip_idx < 32'(N_HARTS));

    assign w_msip_h = w_msip_idx[HART_SEL_W-1:0];
    assign w_cmp_h  = w_cmp_idx[HART_SEL_W-1:0];
    assign w_ssip_h = w_ssip_idx[HART_SEL_W-1:0];

    assign w_ctrl_sel  = (w_a == CTRL_ADDR);
    assign w_presc_sel = (w_a == PRESC_ADDR);
    assign w_mtlo_sel  = (w_a == MTIME_ADDR);
    assign w_mthi_sel  = (w_a == MTIME_ADDR + 32'd4);

    // ---------------- read mux ----------------
    always_comb begin
        w_rdata = '0;
        if (w_msip_hit)
            w_rdata[0] = r_msip[w_msip_h];
        else if (w_cmp_hit)
            w_rdata = w_a[2] ? r_mtimecmp[w_cmp_h][63:32] : r_mtimecmp[w_cmp_h][31:0];
        else if (w_ctrl_sel)
            w_rdata[CTRL_TEN_BIT] = r_ten;
        else if (w_presc_sel)
            w_rdata = 32'(r_presc);
        else if (w_mtlo_sel)
            w_rdata = r_mtime[31:0];
        else if (w_mthi_sel)
            w_rdata = r_hi_shadow;
        else if (w_ssip_hit)
            w_rdata[0] = r_ssip[w_ssip_h];
    end

    // ---------------- prescaler ----------------
    iob_aclint_tick #(
        .PRESC_W (PRESC_W)
    ) u_tick (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .cke_i    (cke_i),
        .en       (r_ten),
        .presc    (r_presc),
        .clr      (w_wr & w_presc_sel),
        .tick     (w_tick)
    );

    // ---------------- register file ----------------
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_ready     <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_mtime     <= '0;
            r_mtimecmp  <= '1;
            r_msip      <= '0;
            r_ssip      <= '0;
            r_ten       <= 1'b1;
            r_presc     <= PRESC_W'(PRESC_RST);
            r_hi_shadow <= '0;
        end else if (cke_i) begin
            r_ready  <= 1'b1;
            r_rvalid <= w_rd;
            if (w_rd) r_rdata <= w_rdata;
            // Low-word read latches the upper half so a following hi read is coherent
            if (w_rd && w_mtlo_sel) r_hi_shadow <= r_mtime[63:32];

            if (w_wr) begin
                if (w_msip_hit && iob_wstrb_i[0]) r_msip[w_msip_h] <= iob_wdata_i[0];
                if (w_ssip_hit && iob_wstrb_i[0]) r_ssip[w_ssip_h] <= iob_wdata_i[0];
                if (w_ctrl_sel && iob_wstrb_i[0]) r_ten <= iob_wdata_i[CTRL_TEN_BIT];
                if (w_presc_sel)
                    r_presc <= PRESC_W'(wmerge(32'(r_presc), iob_wdata_i, iob_wstrb_i));
                if (w_cmp_hit) begin
                    if (w_a[2])
                        r_mtimecmp[w_cmp_h][63:32] <=
                            wmerge(r_mtimecmp[w_cmp_h][63:32], iob_wdata_i, iob_wstrb_i);
                    else
                        r_mtimecmp[w_cmp_h][31:0] <=
                            wmerge(r_mtimecmp[w_cmp_h][31:0], iob_wdata_i, iob_wstrb_i);
                end
            end

            // A bus write to either MTIME half swallows a coincident increment
            if (w_wr && w_mtlo_sel)
                r_mtime[31:0] <= wmerge(r_mtime[31:0], iob_wdata_i, iob_wstrb_i);
            else if (w_wr && w_mthi_sel)
                r_mtime[63:32] <= wmerge(r_mtime[63:32], iob_wdata_i, iob_wstrb_i);
            else if (w_tick && r_ten)
                r_mtime <= r_mtime + 64'd1;
        end
    end

    // Timer compare is registered: one cycle behind either operand
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_mtip <= '0;
        end else if (cke_i) begin
            for (int h = 0; h < N_HARTS; h++)
                r_mtip[h] <= (r_mtime >= r_mtimecmp[h]);
        end
    end

    assign iob_ready_o  = r_ready;
    assign iob_rvalid_o = r_rvalid;
    assign iob_rdata_o  = r_rdata;
    assign mtip_o       = r_mtip;
    assign msip_o       = r_msip;
    assign ssip_o       = r_ssip;

endmodule

// File: tb/tb_iob_aclint.sv
// tb_iob_aclint: directed self-checking bench for iob_aclint (4 harts,
// PRESC_RST=99). Linear stimulus with hand-computed expectations.
module tb_iob_aclint;

    localparam int NH = 4;

    logic          clk;
    logic          arst_n;
    logic          cke;
    logic          avalid;
    logic [15:0]   addr;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          rvalid;
    logic [31:0]   rdata;
    logic          ready;
    logic [NH-1:0] mtip, msip, ssip;

    int n_vec = 0;
    int n_err = 0;

    iob_aclint #(
        .N_HARTS   (NH),
        .ADDR_W    (16),
        .DATA_W    (32),
        .PRESC_W   (16),
        .PRESC_RST (99)
    ) dut (
        .clk_i        (clk),
        .arst_n_i     (arst_n),
        .cke_i        (cke),
        .iob_avalid_i (avalid),
        .iob_addr_i   (addr),
        .iob_wdata_i  (wdata),
        .iob_wstrb_i  (wstrb),
        .iob_rvalid_o (rvalid),
        .iob_rdata_o  (rdata),
        .iob_ready_o  (ready),
        .mtip_o       (mtip),
        .msip_o       (msip),
        .ssip_o       (ssip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a posedge; the write lands on the next posedge
    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        avalid = 1'b1; addr = a; wdata = d; wstrb = s;
        @(posedge clk); #1;
        avalid = 1'b0; wstrb = 4'h0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d);
        avalid = 1'b1; addr = a; wstrb = 4'h0;
        @(posedge clk); #1;
        avalid = 1'b0;
        chk("rvalid", 64'(rvalid), 64'd1);
        d = rdata;
    endtask

    logic [31:0] v;

    initial begin
        arst_n = 1'b0; cke = 1'b1; avalid = 1'b0;
        addr = '0; wdata = '0; wstrb = '0;

        // ---- reset values ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",  64'(ready),  64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rdata",  64'(rdata),  64'd0);
        chk("rst_mtip",   64'(mtip),   64'd0);
        chk("rst_msip",   64'(msip),   64'd0);
        chk("rst_ssip",   64'(ssip),   64'd0);
        arst_n = 1'b1;
        chk("ready_before_edge", 64'(ready), 64'd0);
        @(posedge clk); #1;
        chk("ready_after_rst", 64'(ready), 64'd1);

        rd(16'hBFF8, v);
        chk("mtime_lo_init", 64'(v), 64'd0);
        rd(16'hBFF4, v);
        chk("presc_rst", 64'(v), 64'd99);
        rd(16'hBFF0, v);
        chk("ctrl_rst", 64'(v), 64'd1);
        rd(16'h4004, v);
        chk("cmp0_hi_rst", 64'(v), 64'hFFFF_FFFF);

        // ---- default prescaler: ~10 ticks in 1000 cycles ----
        repeat (1000) @(posedge clk);
        #1;
        rd(16'hBFF8, v);
        chk("mtime_1000cyc_range", 64'((v >= 32'd9) && (v <= 32'd11)), 64'd1);
        chk("mtip_idle", 64'(mtip), 64'd0);

        // ---- compare: PRESCALE=0, mtime from 0x10, mtimecmp[1]=0x20 ----
        wr(16'hBFF0, 32'd0, 4'hF);
        wr(16'hBFF4, 32'd0, 4'hF);
        wr(16'hBFFC, 32'd0, 4'hF);
        wr(16'hBFF8, 32'h10, 4'hF);
        wr(16'h4008, 32'h20, 4'hF);
        wr(16'h400C, 32'd0, 4'hF);
        rd(16'h4008, v);
        chk("cmp1_lo_rb", 64'(v), 64'h20);
        chk("mtip1_pre", 64'(mtip[1]), 64'd0);
        wr(16'hBFF0, 32'd1, 4'hF);
        // first tick registers one edge after enable, then mtime counts every edge;
        // mtime becomes 0x20 on the 17th edge, mtip follows on the 18th
        repeat (17) @(posedge clk);
        #1;
        chk("mtip1_at_match", 64'(mtip[1]), 64'd0);
        @(posedge clk); #1;
        chk("mtip1_rise", 64'(mtip[1]), 64'd1);
        chk("mtip0_low",  64'(mtip[0]), 64'd0);

        // ---- wrap and coherent snapshot ----
        wr(16'hBFF0, 32'd0, 4'hF);
        wr(16'hBFFC, 32'hFFFF_FFFF, 4'hF);
        wr(16'hBFF8, 32'hFFFF_FFFE, 4'hF);
        rd(16'hBFF8, v);
        chk("pre_wrap_lo", 64'(v), 64'hFFFF_FFFE);
        rd(16'hBFFC, v);
        chk("pre_wrap_hi", 64'(v), 64'hFFFF_FFFF);
        chk("mtip1_pre_wrap", 64'(mtip[1]), 64'd1);
        wr(16'hBFF0, 32'd1, 4'hF);
        @(posedge clk);
        @(posedge clk); #1;
        wr(16'hBFF0, 32'd0, 4'hF);   // two increments taken: ...FFFE -> ...FFFF -> 0
        rd(16'hBFF8, v);
        chk("wrap_lo", 64'(v), 64'd0);
        chk("mtip1_after_wrap", 64'(mtip[1]), 64'd0);
        rd(16'hBFFC, v);
        chk("wrap_hi", 64'(v), 64'd0);

        // ---- byte strobe into MTIMECMP[0] lo ----
        wr(16'h4000, 32'hAABB_CCDD, 4'b0010);
        rd(16'h4000, v);
        chk("strobe_cmp0_lo", 64'(v), 64'hFFFF_CCFF);

        // ---- software interrupts ----
        wr(16'h0008, 32'd1, 4'hF);
        chk("msip2_set", 64'(msip), 64'b0100);
        wr(16'h0008, 32'd0, 4'b0010);
        chk("msip2_no_b0_strobe", 64'(msip), 64'b0100);
        wr(16'hC000, 32'd1, 4'hF);
        chk("ssip0_set", 64'(ssip), 64'b0001);
        rd(16'h0008, v);
        chk("msip2_rd", 64'(v), 64'd1);
        rd(16'(4 * NH), v);
        chk("msip_oob_rd", 64'(v), 64'd0);
        wr(16'(4 * NH), 32'd1, 4'hF);
        chk("msip_oob_wr_ignored", 64'(msip), 64'b0100);
        rd(16'hC000, v);
        chk("ssip0_rd", 64'(v), 64'd1);
        rd(16'h4020, v);
        chk("cmp_oob_rd", 64'(v), 64'd0);
        rd(16'h9000, v);
        chk("unmapped_rd", 64'(v), 64'd0);

        // ---- TEN=0 holds mtime ----
        wr(16'hBFF8, 32'h1234, 4'hF);
        repeat (500) @(posedge clk);
        #1;
        rd(16'hBFF8, v);
        chk("ten0_hold", 64'(v), 64'h1234);

        // ---- MTIME write beats a coincident increment ----
        wr(16'hBFF0, 32'd1, 4'hF);
        @(posedge clk); #1;          // tick now pending every cycle
        wr(16'hBFF8, 32'h100, 4'hF); // write wins, increment dropped
        wr(16'hBFF0, 32'd0, 4'hF);   // one more increment while TEN still 1
        rd(16'hBFF8, v);
        chk("write_beats_tick", 64'(v), 64'h101);

        // ---- reset during a read response aborts it ----
        avalid = 1'b1; addr = 16'hBFF8; wstrb = 4'h0;
        @(posedge clk); #1;
        avalid = 1'b0;
        arst_n = 1'b0;
        #1;
        chk("rst_abort_rvalid", 64'(rvalid), 64'd0);
        chk("rst_abort_msip",   64'(msip),   64'd0);
        @(posedge clk); #1;
        chk("rst_abort_rvalid2", 64'(rvalid), 64'd0);
        arst_n = 1'b1;
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
